if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- PC register plus IF/ID pipeline latch for the 5-stage MIPS pipeline.
- Drives instruction-memory address, captures the fetched word into IF/ID, and presents opCode/rs/rt to the branch stall-control and decode logic.
- Consumes stallSignal from branch stall control: hold on stall, flush on taken branch/jump resolved in ID.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction inserted into IF/ID on flush or reset (sll $0,$0,0)
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stallSignal  in  1  from branch stall control; 1 = freeze PC and IF/ID
- branchTaken  in  1  ID-stage beq resolved taken
- branchTarget  in  32  ID-stage computed branch address
- jump  in  1  ID-stage j instruction
- jumpTarget  in  32  ID-stage jump address
- imemData  in  32  instruction word at imemAddr (combinational memory read)
- imemAddr  out  32  current PC
- IF_ID_instr  out  32  latched instruction
- IF_ID_pcPlus4  out  32  latched PC+4
- IF_ID_valid  out  1  0 = bubble
- opCode  out  6  IF_ID_instr[31:26]
- IF_ID_rs  out  5  IF_ID_instr[25:21]
- IF_ID_rt  out  5  IF_ID_instr[20:16]
- IF_ID_rd  out  5  IF_ID_instr[15:11]
- stallCount  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=1 at clk edge): PC=RESET_PC, IF_ID_instr=NOP_WORD, IF_ID_pcPlus4=0, IF_ID_valid=0, stallCount=0. Reset overrides every other input. Asserting rst mid-stall or mid-flush discards all pending state.
- imemAddr = PC, combinational. Field outputs are combinational slices of IF_ID_instr.
- Per-edge priority (rst=0):
  1. stallSignal=1: PC, IF_ID_instr, IF_ID_pcPlus4 and IF_ID_valid all hold. branchTaken/jump are ignored, because the branch in ID has unresolved operands. stallCount increments, saturating at all-ones.
  2. Otherwise branchTaken=1: PC=branchTarget; IF_ID_instr=NOP_WORD, IF_ID_valid=0, IF_ID_pcPlus4=0. This flushes the wrong-path fetch, giving one bubble.
  3. Otherwise jump=1: same as 2, using jumpTarget.
  4. Otherwise: PC=PC+4 (mod 2^32; wraps 32'hFFFF_FFFC to 0); IF_ID_instr=imemData; IF_ID_pcPlus4=PC+4; IF_ID_valid=1.
- branchTaken and jump both 1 (illegal): branchTaken wins.
- Latency: a word at PC appears in IF_ID_instr one edge after fetch with no stall. A stall of N cycles delays it N edges.
- Multi-cycle stall: lw then beq produces 2 consecutive stall cycles. PC and IF/ID must stay bit-identical throughout. The cycle after stallSignal drops resumes per priority 2–4.
- A bubble (IF_ID_valid=0) presents opCode=0 and rd=0. Downstream treats it as a harmless R-type writing $0.
- PC low 2 bits are not forced. Targets are used as given.
- stallCount is never cleared except by rst.

Test Plan:
- Reset: rst=1 for 2 edges with RESET_PC=0 → imemAddr=0, IF_ID_valid=0, IF_ID_instr=0, stallCount=0. After release, imemAddr steps 0,4,8 and IF_ID_pcPlus4 lags by one edge (4,8,...).
- Stall hold: at PC=0x10 with IF_ID_instr=0x1022_0003 (beq), assert stallSignal for 2 edges → PC stays 0x10, IF_ID unchanged, stallCount=2. On release, PC=0x14.
- Stall vs branch: stallSignal=1 and branchTaken=1 with branchTarget=0x40 on the same edge → PC holds and no flush occurs. Next edge with stallSignal=0 and branchTaken=1 → PC=0x40, IF_ID_valid=0, IF_ID_instr=0.
- Jump flush: jump=1 with jumpTarget=0x100 → PC=0x100 and IF/ID bubble. Next edge captures imemData@0x100 with IF_ID_pcPlus4=0x104.
- Wrap and saturation: force PC=0xFFFF_FFFC with no stall → next PC=0. With STALL_CNT_W=4, hold stallSignal for 20 edges → stallCount=15.
- Reset mid-stall: rst=1 while stallSignal=1 → PC=RESET_PC, IF_ID_valid=0, stallCount=0 on that edge.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// Fetch stage for the 5-stage MIPS pipeline: PC register, IF/ID latch and a
// saturating stall counter. Stall freezes everything; a taken branch or jump flushes IF/ID.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallSignal,
  input  logic                   branchTaken,
  input  logic [31:0]            branchTarget,
  input  logic                   jump,
  input  logic [31:0]            jumpTarget,
  input  logic [31:0]            imemData,
  output logic [31:0]            imemAddr,
  output logic [31:0]            IF_ID_instr,
  output logic [31:0]            IF_ID_pcPlus4,
  output logic                   IF_ID_valid,
  output logic [5:0]             opCode,
  output logic [4:0]             IF_ID_rs,
  output logic [4:0]             IF_ID_rt,
  output logic [4:0]             IF_ID_rd,
  output logic [STALL_CNT_W-1:0] stallCount
);

  logic [31:0]            pc;
  logic [31:0]            pc_plus4;
  logic [31:0]            instr_q;
  logic [31:0]            pc_plus4_q;
  logic                   valid_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  assign pc_plus4 = pc + 32'd4;

  // Stall outranks branch/jump: a branch waiting on a stall has unresolved operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      stall_cnt  <= '0;
    end else if (stallSignal) begin
      if (stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end else if (branchTaken) begin
      pc         <= branchTarget;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else if (jump) begin
      pc         <= jumpTarget;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      pc         <= pc_plus4;
      instr_q    <= imemData;
      pc_plus4_q <= pc_plus4;
      valid_q    <= 1'b1;
    end
  end

  assign imemAddr      = pc;
  assign IF_ID_instr   = instr_q;
  assign IF_ID_pcPlus4 = pc_plus4_q;
  assign IF_ID_valid   = valid_q;
  assign opCode        = instr_q[31:26];
  assign IF_ID_rs      = instr_q[25:21];
  assign IF_ID_rt      = instr_q[20:16];
  assign IF_ID_rd      = instr_q[15:11];
  assign stallCount    = stall_cnt;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: a table of per-edge vectors with
// hand-computed PC / IF-ID / counter values, then a long-stall saturation sequence.
module tb_if_id_fetch_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, stallSignal, branchTaken, jump;
  logic [31:0]   branchTarget, jumpTarget, imemData;
  logic [31:0]   imemAddr, IF_ID_instr, IF_ID_pcPlus4;
  logic          IF_ID_valid;
  logic [5:0]    opCode;
  logic [4:0]    IF_ID_rs, IF_ID_rt, IF_ID_rd;
  logic [CW-1:0] stallCount;

  int tests = 0;
  int fails = 0;

  if_id_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stallSignal(stallSignal), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .jump(jump), .jumpTarget(jumpTarget),
    .imemData(imemData), .imemAddr(imemAddr), .IF_ID_instr(IF_ID_instr),
    .IF_ID_pcPlus4(IF_ID_pcPlus4), .IF_ID_valid(IF_ID_valid), .opCode(opCode),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_rd(IF_ID_rd),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a beq at 0x0C, otherwise a tagged copy of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h1022_0003;
    return 32'h2000_0000 | a;
  endfunction

  assign imemData = mem_word(imemAddr);

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] pc, instr, pc4;
    logic        valid;
    logic [3:0]  cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] pc4, input logic valid, input logic [3:0] cnt);
    logic [31:0] ins;
    ins = instr;
    tests++;
    if (imemAddr !== pc || IF_ID_instr !== instr || IF_ID_pcPlus4 !== pc4 ||
        IF_ID_valid !== valid || stallCount !== cnt || opCode !== ins[31:26] ||
        IF_ID_rs !== ins[25:21] || IF_ID_rt !== ins[20:16] || IF_ID_rd !== ins[15:11]) begin
      fails++;
      $display("FAIL %s: got pc=%h instr=%h pc4=%h v=%b cnt=%0d op=%0d rs=%0d rt=%0d rd=%0d; want pc=%h instr=%h pc4=%h v=%b cnt=%0d",
               name, imemAddr, IF_ID_instr, IF_ID_pcPlus4, IF_ID_valid, stallCount,
               opCode, IF_ID_rs, IF_ID_rt, IF_ID_rd, pc, instr, pc4, valid, cnt);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    @(negedge clk);
    rst = r; stallSignal = s; branchTaken = b; branchTarget = bt; jump = j; jumpTarget = jt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst  stl  br   brt           jmp  jt            pc            instr         pc4           v    cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,4'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,4'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'h2000_0000,32'h4,        1'b1,4'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h8,        32'h2000_0004,32'h8,        1'b1,4'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'hC,        32'h2000_0008,32'hC,        1'b1,4'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h10,       32'h1022_0003,32'h10,       1'b1,4'd0};
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h10,       32'h1022_0003,32'h10,       1'b1,4'd1};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        32'h10,       32'h1022_0003,32'h10,       1'b1,4'd2};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h14,       32'h2000_0010,32'h14,       1'b1,4'd2};
    vecs[9]  = '{1'b0,1'b1,1'b1,32'h40,       1'b0,32'h0,        32'h14,       32'h2000_0010,32'h14,       1'b1,4'd3};
    vecs[10] = '{1'b0,1'b0,1'b1,32'h40,       1'b0,32'h0,        32'h40,       32'h0,        32'h0,        1'b0,4'd3};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h44,       32'h2000_0040,32'h44,       1'b1,4'd3};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h100,      32'h100,      32'h0,        32'h0,        1'b0,4'd3};
    vecs[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h104,      32'h2000_0100,32'h104,      1'b1,4'd3};
    vecs[14] = '{1'b0,1'b0,1'b1,32'h200,      1'b1,32'h300,      32'h200,      32'h0,        32'h0,        1'b0,4'd3};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h0,        32'h0,        1'b0,4'd3};
    vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0,        32'hFFFF_FFFC,32'h0,        1'b1,4'd3};
    vecs[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h4,        32'h2000_0000,32'h4,        1'b1,4'd3};
    vecs[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h80,       32'h4,        32'h2000_0000,32'h4,        1'b1,4'd4};
    vecs[19] = '{1'b1,1'b1,1'b1,32'h40,       1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0,4'd0};

    rst = 1'b1; stallSignal = 1'b0; branchTaken = 1'b0; jump = 1'b0;
    branchTarget = 32'h0; jumpTarget = 32'h0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].jmp, vecs[i].jt);
      check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
            vecs[i].valid, vecs[i].cnt);
    end

    // Long stall straight out of reset: counter climbs to 15 and saturates, state frozen.
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
      if (k == 14) check("stall14", 32'h0, 32'h0, 32'h0, 1'b0, 4'd14);
      if (k == 15) check("stall15", 32'h0, 32'h0, 32'h0, 1'b0, 4'd15);
    end
    check("stall_sat", 32'h0, 32'h0, 32'h0, 1'b0, 4'd15);

    // Release: fetch resumes, counter is not cleared.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("resume", 32'h4, 32'h2000_0000, 32'h4, 1'b1, 4'd15);

    // Only reset clears the counter.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst_clr", 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
